// File: rtl/bist_datapath_pkg.sv
// Shared constants for the memory BIST datapath: default widths and the
// all-ones address used as the down-count start and the up-count terminal.
package bist_datapath_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    localparam logic [ADDR_W_DEF-1:0] ALL_ONES = '1;

    // Terminal address for the selected count direction.
    function automatic logic [ADDR_W_DEF-1:0] terminal_addr(input logic up_down);
        return up_down ? ALL_ONES : '0;
    endfunction

endpackage

// File: rtl/bist_addr_cnt.sv
// Up/down address counter with synchronous load-zero and load-all-ones.
// Wraps modulo 2^ADDR_W. carry flags the terminal address of the current
// direction while counting is enabled.
module bist_addr_cnt
    import bist_datapath_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_down,
    input  logic              reset,
    input  logic              preset,
    output logic [ADDR_W-1:0] addr,
    output logic              carry
);

    logic [ADDR_W-1:0] r_addr;
    logic              w_at_top;
    logic              w_at_bot;

    assign w_at_top = (r_addr == {ADDR_W{1'b1}});
    assign w_at_bot = (r_addr == '0);

    // Address register: reset > preset > count > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (reset) begin
            r_addr <= '0;
        end else if (preset) begin
            r_addr <= {ADDR_W{1'b1}};
        end else if (en) begin
            if (up_down) begin
                r_addr <= r_addr + ADDR_W'(1);
            end else begin
                r_addr <= r_addr - ADDR_W'(1);
            end
        end
    end

    // Terminal flag; held low while the block is in reset.
    always_comb begin
        carry = rst_n & en & ((up_down & w_at_top) | (~up_down & w_at_bot));
    end

    assign addr = r_addr;

endmodule

// File: rtl/bist_datapath.sv
// Memory BIST datapath: address generation, memory strobes, registered
// read-compare pipeline and a sticky fail log (first fail address plus a
// saturating miscompare count).
module bist_datapath
    import bist_datapath_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_down,
    input  logic              reset,
    input  logic              preset,
    input  logic              read,
    input  logic              write,
    input  logic              data,
    input  logic              clr,
    output logic              carry,
    output logic              is_equal,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [CNT_W-1:0]  fail_cnt
);

    logic [ADDR_W-1:0] w_addr;
    logic              w_carry;
    logic [DATA_W-1:0] w_pattern;
    logic              w_mem_re;
    logic              w_mem_we;
    logic              w_miscompare;

    logic              r_pend;
    logic [DATA_W-1:0] r_exp_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_first_fail_addr;
    logic [CNT_W-1:0]  r_fail_cnt;

    bist_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up_down (up_down),
        .reset   (reset),
        .preset  (preset),
        .addr    (w_addr),
        .carry   (w_carry)
    );

    // Strobes: a simultaneous read and write request is treated as invalid
    // and neither strobe is issued.
    always_comb begin
        w_pattern = {DATA_W{data}};
        w_mem_we  = write & en & ~read;
        w_mem_re  = read & en & ~write;
    end

    // Read pipeline: capture expected word and address alongside each read
    // so the compare lines up with mem_rdata one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= 1'b0;
            r_exp_q  <= '0;
            r_addr_q <= '0;
        end else if (w_mem_re) begin
            r_pend   <= 1'b1;
            r_exp_q  <= w_pattern;
            r_addr_q <= w_addr;
        end else begin
            r_pend   <= 1'b0;
        end
    end

    // Compare is only meaningful while a read is pending.
    always_comb begin
        w_miscompare = r_pend & (mem_rdata != r_exp_q);
    end

    // Fail log: clear wins over a simultaneous miscompare; only the first
    // miscompare after a clear records its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_valid      <= 1'b0;
            r_first_fail_addr <= '0;
            r_fail_cnt        <= '0;
        end else if (clr) begin
            r_fail_valid      <= 1'b0;
            r_first_fail_addr <= '0;
            r_fail_cnt        <= '0;
        end else if (w_miscompare) begin
            if (r_fail_cnt != {CNT_W{1'b1}}) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
            if (!r_fail_valid) begin
                r_fail_valid      <= 1'b1;
                r_first_fail_addr <= r_addr_q;
            end
        end
    end

    assign carry           = w_carry;
    assign is_equal        = ~w_miscompare;
    assign mem_addr        = w_addr;
    assign mem_we          = w_mem_we;
    assign mem_re          = w_mem_re;
    assign mem_wdata       = w_pattern;
    assign fail_valid      = r_fail_valid;
    assign first_fail_addr = r_first_fail_addr;
    assign fail_cnt        = r_fail_cnt;

endmodule

// File: tb/tb_bist_datapath.sv
// Directed bench for bist_datapath: sweeps, fault injection, saturation
// (second instance with a 2-bit counter), clear priority and mid-pass reset.
module tb_bist_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_down, reset, preset, read, write, data, clr;
    logic       carry, is_equal, mem_we, mem_re, fail_valid;
    logic [3:0] mem_addr, first_fail_addr;
    logic [7:0] mem_wdata, mem_rdata, fail_cnt;

    logic       b_carry, b_is_equal, b_mem_we, b_mem_re, b_fail_valid;
    logic [3:0] b_mem_addr, b_first_fail_addr;
    logic [7:0] b_mem_wdata;
    logic [1:0] b_fail_cnt;

    logic [7:0] mem   [16];
    logic [7:0] stuck [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bist_datapath dut (
        .clk (clk), .rst_n (rst_n), .en (en), .up_down (up_down),
        .reset (reset), .preset (preset), .read (read), .write (write),
        .data (data), .clr (clr), .carry (carry), .is_equal (is_equal),
        .mem_addr (mem_addr), .mem_we (mem_we), .mem_re (mem_re),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
        .fail_valid (fail_valid), .first_fail_addr (first_fail_addr),
        .fail_cnt (fail_cnt)
    );

    bist_datapath #(.CNT_W (2)) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en), .up_down (up_down),
        .reset (reset), .preset (preset), .read (read), .write (write),
        .data (data), .clr (clr), .carry (b_carry), .is_equal (b_is_equal),
        .mem_addr (b_mem_addr), .mem_we (b_mem_we), .mem_re (b_mem_re),
        .mem_wdata (b_mem_wdata), .mem_rdata (mem_rdata),
        .fail_valid (b_fail_valid), .first_fail_addr (b_first_fail_addr),
        .fail_cnt (b_fail_cnt)
    );

    // Memory model: synchronous write, read data one cycle after mem_re,
    // stuck-at-1 bits OR'd into the returned word.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr] | stuck[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; up_down = 1; reset = 0; preset = 0;
        read = 0; write = 0; data = 0; clr = 0;
    endtask

    task automatic clear_stuck();
        for (int k = 0; k < 16; k++) stuck[k] = 8'h00;
    endtask

    // Load address 0, then one up read pass of data=0 over all 16 words,
    // then one idle cycle so the last read is compared. clr_at selects a
    // pass cycle on which clr is raised (-1 for none).
    task automatic up_read_pass(input int clr_at);
        idle(); reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 16; i++) begin
            en = 1; up_down = 1; read = 1; data = 0; clr = (i == clr_at);
            #1;
            chk("rd_addr", mem_addr, i);
            chk("rd_eq", is_equal, (i == 0) ? 1'b1 : (stuck[i-1] == 8'h00));
            tick();
        end
        idle();
        #1;
        chk("rd_eq_tail", is_equal, stuck[15] == 8'h00);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        clear_stuck();

        // Reset behaviour: carry forced low even at addr 0 counting down,
        // strobes follow their inputs.
        rst_n = 0; idle(); en = 1; up_down = 0; write = 1;
        #2;
        chk("rst_addr", mem_addr, 0);
        chk("rst_carry", carry, 0);
        chk("rst_eq", is_equal, 1);
        chk("rst_we", mem_we, 1);
        chk("rst_re", mem_re, 0);
        chk("rst_fv", fail_valid, 0);
        chk("rst_cnt", fail_cnt, 0);
        chk("rst_ffa", first_fail_addr, 0);
        write = 0; read = 1;
        #1;
        chk("rst_re_follow", mem_re, 1);
        idle();
        #8 rst_n = 1;
        tick();

        // Write pattern side checks, and read+write suppression.
        data = 1;
        #1;
        chk("wdata_ones", mem_wdata, 8'hFF);
        chk("we_no_en", mem_we, 0);
        en = 1; read = 1; write = 1;
        #1;
        chk("rw_we_supp", mem_we, 0);
        chk("rw_re_supp", mem_re, 0);
        idle();
        #1;

        // Up sweep writing zeros.
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 16; i++) begin
            en = 1; up_down = 1; write = 1; data = 0;
            #1;
            chk("up_addr", mem_addr, i);
            chk("up_we", mem_we, 1);
            chk("up_carry", carry, i == 15);
            tick();
        end
        idle();
        #1;
        chk("up_wrap", mem_addr, 0);

        // Down sweep reading zeros from 15 to 0.
        preset = 1;
        tick();
        preset = 0;
        for (int i = 15; i >= 0; i--) begin
            en = 1; up_down = 0; read = 1; data = 0;
            #1;
            chk("dn_addr", mem_addr, i);
            chk("dn_re", mem_re, 1);
            chk("dn_carry", carry, i == 0);
            chk("dn_eq", is_equal, 1);
            tick();
        end
        idle();
        #1;
        chk("dn_wrap", mem_addr, 15);
        chk("dn_eq_tail", is_equal, 1);
        tick();
        chk("dn_fv", fail_valid, 0);
        chk("dn_cnt", fail_cnt, 0);

        // Single stuck bit at address 5.
        stuck[5] = 8'h01;
        up_read_pass(-1);
        chk("f5_fv", fail_valid, 1);
        chk("f5_ffa", first_fail_addr, 5);
        chk("f5_cnt", fail_cnt, 1);

        // clr clears the log but leaves the address alone.
        clr = 1;
        #1;
        chk("clr_addr_pre", mem_addr, 0);
        tick();
        clr = 0;
        chk("clr_fv", fail_valid, 0);
        chk("clr_cnt", fail_cnt, 0);
        chk("clr_ffa", first_fail_addr, 0);
        chk("clr_addr_post", mem_addr, 0);

        // Two faults: first address sticks at 3.
        clear_stuck();
        stuck[3] = 8'h80; stuck[9] = 8'h10;
        up_read_pass(-1);
        chk("f39_ffa", first_fail_addr, 3);
        chk("f39_cnt", fail_cnt, 2);
        chk("f39_cnt_b", b_fail_cnt, 2);

        // Five faults incl. the last address: narrow counter saturates, the
        // final read is logged after en drops.
        clr = 1; tick(); clr = 0;
        clear_stuck();
        stuck[1] = 8'h01; stuck[4] = 8'h02; stuck[7] = 8'h04;
        stuck[10] = 8'h08; stuck[15] = 8'h40;
        up_read_pass(-1);
        chk("sat_cnt", fail_cnt, 5);
        chk("sat_cnt_b", b_fail_cnt, 3);
        chk("sat_ffa", first_fail_addr, 1);
        chk("sat_fv_b", b_fail_valid, 1);

        // clr coincident with the only miscompare (pend for addr 2 on cycle 3).
        clr = 1; tick(); clr = 0;
        clear_stuck();
        stuck[2] = 8'hFF;
        up_read_pass(3);
        chk("clrpri_cnt", fail_cnt, 0);
        chk("clrpri_fv", fail_valid, 0);

        // Mid-pass reset aborts a pending miscompare and clears the log.
        clear_stuck();
        stuck[2] = 8'h01; stuck[6] = 8'h01;
        idle(); reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 7; i++) begin
            en = 1; up_down = 1; read = 1; data = 0;
            tick();
        end
        #1;
        chk("ab_addr_pre", mem_addr, 7);
        chk("ab_eq_pre", is_equal, 0);
        chk("ab_cnt_pre", fail_cnt, 1);
        chk("ab_ffa_pre", first_fail_addr, 2);
        rst_n = 0;
        #1;
        chk("ab_addr", mem_addr, 0);
        chk("ab_eq", is_equal, 1);
        chk("ab_fv", fail_valid, 0);
        chk("ab_cnt", fail_cnt, 0);
        idle();
        #1 rst_n = 1;
        tick();
        chk("ab_cnt_post", fail_cnt, 0);
        chk("ab_fv_post", fail_valid, 0);
        chk("ab_ffa_post", first_fail_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
